// File: rtl/seq_cla_adder_pkg.sv
// Shared constants and FSM state encoding for the sequential CLA adder.
package seq_cla_adder_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 32;
  localparam int unsigned DEFAULT_GROUP_BIT  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/seq_cla_adder_cla_group_adder.sv
// One carry-lookahead group: every carry is a flat sum of products of g/p terms.
module cla_group_adder #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             cmsb,
  output logic             gp,
  output logic             gg
);

  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] g;
  logic [WIDTH:0]   c;

  // Expand c(i+1) = g(i) | p(i)g(i-1) | ... | p(i..0)cin for every bit.
  always_comb begin
    logic acc;
    logic pp;
    p    = a ^ b;
    g    = a & b;
    c    = '0;
    gg   = 1'b0;
    acc  = 1'b0;
    pp   = 1'b0;
    c[0] = cin;
    for (int i = 0; i < int'(WIDTH); i++) begin
      acc = g[i];
      pp  = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        acc = acc | (pp & g[j]);
        pp  = pp & p[j];
      end
      if (i == int'(WIDTH) - 1) begin
        gg = acc;
      end
      c[i+1] = acc | (pp & cin);
    end
  end

  assign sum  = p ^ c[WIDTH-1:0];
  assign cout = c[WIDTH];
  assign cmsb = c[WIDTH-1];
  assign gp   = &p;

endmodule

// File: rtl/seq_cla_adder.sv
// Multi-cycle adder: one GROUP_BIT-wide lookahead group per clock, LSB group first.
module seq_cla_adder
  import seq_cla_adder_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned GROUP_BIT  = DEFAULT_GROUP_BIT
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  input  logic                  c_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] sum_o,
  output logic                  c_o,
  output logic                  ovf_o
);

  localparam int unsigned N     = DATA_WIDTH / GROUP_BIT;
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;

  // Reject operand widths that do not split into whole groups.
  if ((GROUP_BIT == 0) || (DATA_WIDTH % GROUP_BIT != 0) || (DATA_WIDTH == 0)) begin : g_bad_width
    $error("seq_cla_adder: DATA_WIDTH must be a nonzero multiple of GROUP_BIT");
  end

  state_e                state;
  state_e                state_next;
  logic                  load_c;
  logic                  step_c;
  logic                  last_c;

  logic [DATA_WIDTH-1:0] a_lat;
  logic [DATA_WIDTH-1:0] b_lat;
  logic                  carry;
  logic [IDX_W-1:0]      idx;
  logic [31:0]           idx_base;

  logic [GROUP_BIT-1:0]  grp_sum;
  logic                  grp_cout;
  logic                  grp_cmsb;
  logic                  grp_gp;
  logic                  grp_gg;

  assign last_c   = (idx == IDX_W'(N - 1));
  assign idx_base = 32'(idx) * GROUP_BIT;

  cla_group_adder #(
    .WIDTH (GROUP_BIT)
  ) u_group (
    .a    (a_lat[idx_base +: GROUP_BIT]),
    .b    (b_lat[idx_base +: GROUP_BIT]),
    .cin  (carry),
    .sum  (grp_sum),
    .cout (grp_cout),
    .cmsb (grp_cmsb),
    .gp   (grp_gp),
    .gg   (grp_gg)
  );

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and datapath control; start is only honoured outside RUN.
  always_comb begin
    state_next = state;
    load_c     = 1'b0;
    step_c     = 1'b0;
    case (state)
      IDLE: begin
        if (start_i) begin
          load_c     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        step_c = 1'b1;
        if (last_c) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (start_i) begin
          load_c     = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Registered status flags track the state being entered.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_o <= 1'b0;
      done_o <= 1'b0;
    end else begin
      busy_o <= (state_next == RUN);
      done_o <= (state_next == DONE);
    end
  end

  // Operand latch, group walk and result accumulation.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_lat <= '0;
      b_lat <= '0;
      carry <= 1'b0;
      idx   <= '0;
      sum_o <= '0;
      c_o   <= 1'b0;
      ovf_o <= 1'b0;
    end else if (load_c) begin
      a_lat <= a_i;
      b_lat <= b_i;
      carry <= c_i;
      idx   <= '0;
      sum_o <= '0;
      c_o   <= 1'b0;
      ovf_o <= 1'b0;
    end else if (step_c) begin
      sum_o[idx_base +: GROUP_BIT] <= grp_sum;
      carry <= grp_gg | (grp_gp & carry);
      idx   <= idx + IDX_W'(1);
      if (last_c) begin
        c_o   <= grp_cout;
        ovf_o <= grp_cmsb ^ grp_cout;
      end
    end
  end

endmodule
